// File: rtl/conv_1x1_sched_pkg.sv
// Shared types and width helpers for the 1x1 convolution layer scheduler.
package conv_1x1_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int unsigned DEF_DATA_WIDTH      = 16;
  localparam int unsigned DEF_CHANNEL_NUM_IN  = 304;
  localparam int unsigned DEF_CHANNEL_NUM_OUT = 256;
  localparam int unsigned DEF_IMAGE_SIZE      = 4096;

  // Counter/address width for a terminal count n; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_1x1_sched_if.sv
// Datapath-side bus of the scheduler: weight memory read port, weight load,
// pixel source handshake, pixel stream and result strobe.
interface conv_1x1_sched_if
  import conv_1x1_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned CHANNEL_NUM_IN  = DEF_CHANNEL_NUM_IN,
  parameter int unsigned CHANNEL_NUM_OUT = DEF_CHANNEL_NUM_OUT
);

  localparam int unsigned AW = cnt_width(CHANNEL_NUM_IN * CHANNEL_NUM_OUT);
  localparam int unsigned OW = cnt_width(CHANNEL_NUM_OUT);

  logic                  wt_rd_en;
  logic [AW-1:0]         wt_addr;
  logic [DATA_WIDTH-1:0] wt_data;
  logic                  valid_weight_in;
  logic [DATA_WIDTH-1:0] weight_in;
  logic                  stride2;
  logic                  src_valid;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_ready;
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] pxl_in;
  logic                  conv_valid_out;
  logic [OW-1:0]         oc_index;

  modport sched (
    output wt_rd_en, wt_addr, valid_weight_in, weight_in, stride2,
           src_ready, valid_in, pxl_in, oc_index,
    input  wt_data, src_valid, src_data, conv_valid_out
  );

  modport env (
    input  wt_rd_en, wt_addr, valid_weight_in, weight_in, stride2,
           src_ready, valid_in, pxl_in, oc_index,
    output wt_data, src_valid, src_data, conv_valid_out
  );

endinterface

// File: rtl/conv_sched_cnt.sv
// Up-counter with synchronous clear and a terminal-count flag; wraps to 0
// when enabled on its last value.
module conv_sched_cnt
  import conv_1x1_sched_pkg::*;
#(
  parameter int unsigned TERMINAL = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           clr,
  output logic [cnt_width(TERMINAL)-1:0] count,
  output logic                           last
);

  localparam int unsigned W = cnt_width(TERMINAL);

  assign last = (count == W'(TERMINAL - 1));

  // Count enabled events, clear has priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/conv_1x1_sched.sv
// Layer scheduler for a 1x1 convolution datapath: per output channel it
// streams CHANNEL_NUM_IN weights, then CHANNEL_NUM_IN*IMAGE_SIZE pixels, then
// waits for IMAGE_SIZE results before moving to the next output channel.
module conv_1x1_sched
  import conv_1x1_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned CHANNEL_NUM_IN  = DEF_CHANNEL_NUM_IN,
  parameter int unsigned CHANNEL_NUM_OUT = DEF_CHANNEL_NUM_OUT,
  parameter int unsigned IMAGE_SIZE      = DEF_IMAGE_SIZE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stride2_cfg,
  output logic            busy,
  output logic            done,
  conv_1x1_sched_if.sched bus
);

  localparam int unsigned AW = cnt_width(CHANNEL_NUM_IN * CHANNEL_NUM_OUT);
  localparam int unsigned WW = cnt_width(CHANNEL_NUM_IN);
  localparam int unsigned BW = cnt_width(CHANNEL_NUM_IN * IMAGE_SIZE);
  localparam int unsigned RW = cnt_width(IMAGE_SIZE);
  localparam int unsigned OW = cnt_width(CHANNEL_NUM_OUT);

  state_t                state;
  logic                  wt_rd_en;
  logic [AW-1:0]         wt_addr;
  logic                  valid_weight_in;
  logic                  stride2;
  logic                  src_ready;
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] pxl_in;
  logic                  res_full;

  logic                  accept;
  logic                  beat;
  logic                  res_en;
  logic                  res_done;
  logic                  drain_exit;

  logic [WW-1:0]         wt_cnt;
  logic [BW-1:0]         beat_cnt;
  logic [RW-1:0]         res_cnt;
  logic [OW-1:0]         oc_cnt;
  logic                  wt_last;
  logic                  beat_last;
  logic                  res_last;
  logic                  oc_last;
  logic                  unused_cnt_bits;

  assign unused_cnt_bits = ^{wt_cnt, beat_cnt, res_cnt};

  assign accept     = (state == S_IDLE) && start;
  assign beat       = bus.src_valid && src_ready;
  // res_full remembers a complete result set that arrived before RUN ended.
  assign res_en     = bus.conv_valid_out && ((state == S_RUN) || (state == S_DRAIN)) && !res_full;
  assign res_done   = res_full || (res_en && res_last);
  assign drain_exit = (state == S_DRAIN) && res_done;

  conv_sched_cnt #(.TERMINAL(CHANNEL_NUM_IN)) u_wt_cnt (
    .clk(clk), .reset(reset), .en(wt_rd_en), .clr(accept),
    .count(wt_cnt), .last(wt_last)
  );

  conv_sched_cnt #(.TERMINAL(CHANNEL_NUM_IN * IMAGE_SIZE)) u_beat_cnt (
    .clk(clk), .reset(reset), .en(beat), .clr(accept),
    .count(beat_cnt), .last(beat_last)
  );

  conv_sched_cnt #(.TERMINAL(IMAGE_SIZE)) u_res_cnt (
    .clk(clk), .reset(reset), .en(res_en), .clr(accept || drain_exit),
    .count(res_cnt), .last(res_last)
  );

  conv_sched_cnt #(.TERMINAL(CHANNEL_NUM_OUT)) u_oc_cnt (
    .clk(clk), .reset(reset), .en(drain_exit && !oc_last), .clr(accept),
    .count(oc_cnt), .last(oc_last)
  );

  // Layer FSM with registered control and stream outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      wt_rd_en        <= 1'b0;
      wt_addr         <= '0;
      valid_weight_in <= 1'b0;
      stride2         <= 1'b0;
      src_ready       <= 1'b0;
      valid_in        <= 1'b0;
      pxl_in          <= '0;
      res_full        <= 1'b0;
    end else begin
      valid_weight_in <= wt_rd_en;
      valid_in        <= beat;
      done            <= 1'b0;
      if (beat) begin
        pxl_in <= bus.src_data;
      end
      if (accept || drain_exit) begin
        res_full <= 1'b0;
      end else if (res_en && res_last) begin
        res_full <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LOAD_W;
            stride2  <= stride2_cfg;
            busy     <= 1'b1;
            wt_rd_en <= 1'b1;
            wt_addr  <= '0;
          end
        end
        S_LOAD_W: begin
          if (wt_rd_en) begin
            if (wt_last) begin
              wt_rd_en <= 1'b0;
            end else begin
              wt_addr <= wt_addr + AW'(1);
            end
          end else if (valid_weight_in) begin
            state     <= S_RUN;
            src_ready <= 1'b1;
          end
        end
        S_RUN: begin
          if (beat && beat_last) begin
            state     <= S_DRAIN;
            src_ready <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (drain_exit) begin
            if (oc_last) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              // Address holds oc*CIN + CIN-1 here, so +1 is the next channel's base.
              state    <= S_LOAD_W;
              wt_rd_en <= 1'b1;
              wt_addr  <= wt_addr + AW'(1);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.wt_rd_en        = wt_rd_en;
  assign bus.wt_addr         = wt_addr;
  assign bus.valid_weight_in = valid_weight_in;
  assign bus.weight_in       = valid_weight_in ? bus.wt_data : '0;
  assign bus.stride2         = stride2;
  assign bus.src_ready       = src_ready;
  assign bus.valid_in        = valid_in;
  assign bus.pxl_in          = pxl_in;
  assign bus.oc_index        = oc_cnt;

endmodule

// File: tb/tb_conv_1x1_sched.sv
// Self-checking bench for conv_1x1_sched with CIN=4, COUT=2, IMAGE_SIZE=3.
module tb_conv_1x1_sched;

  localparam int unsigned CIN  = 4;
  localparam int unsigned COUT = 2;
  localparam int unsigned IMG  = 3;
  localparam int unsigned DW   = 16;
  localparam int          RES_DELAY = 20;

  logic clk;
  logic reset;
  logic start;
  logic stride2_cfg;
  logic busy;
  logic done;

  conv_1x1_sched_if #(
    .DATA_WIDTH(DW), .CHANNEL_NUM_IN(CIN), .CHANNEL_NUM_OUT(COUT)
  ) bus ();

  conv_1x1_sched #(
    .DATA_WIDTH(DW), .CHANNEL_NUM_IN(CIN), .CHANNEL_NUM_OUT(COUT), .IMAGE_SIZE(IMG)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stride2_cfg(stride2_cfg),
    .busy(busy), .done(done), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Scoreboards: expected addresses, weights and pixels.
  int          aq[$];
  logic [15:0] wq[$];
  logic [15:0] pq[$];

  int  vin_cnt, done_cnt, stride_err, res_seen, src_seq, res_left, res_wait;
  bit  prev_rdy, prev_wrd, rdy_rise, wrd_rise, acc_pending;
  bit  src_toggle, chk_drain, exp_stride;

  typedef struct {
    bit cfg;
    bit toggle;
    bit chk_drain;
    int exp_vin;
    int exp_done;
  } vec_t;
  vec_t vt[4];

  function automatic logic [15:0] wfun(input int a);
    return 16'(32'h1000 + a * 3);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Weight memory with one-cycle read latency; junk when not read.
  always @(posedge clk) begin
    bus.wt_data <= bus.wt_rd_en ? wfun(int'(bus.wt_addr)) : 16'hBAD0;
  end

  // Monitor, pixel source and datapath result model, all on the falling edge.
  always @(negedge clk) begin
    rdy_rise = bus.src_ready && !prev_rdy;
    wrd_rise = bus.wt_rd_en && !prev_wrd;
    prev_rdy = bus.src_ready;
    prev_wrd = bus.wt_rd_en;
    if (!reset) begin
      bus.src_valid      = 1'b0;
      bus.src_data       = '0;
      bus.conv_valid_out = 1'b0;
      res_left    = 0;
      res_wait    = 0;
      acc_pending = 1'b0;
    end else begin
      if (rdy_rise) res_seen = 0;
      if (bus.conv_valid_out) res_seen++;
      if (bus.valid_weight_in) begin
        if (wq.size() == 0) check("weight_extra", 64'(wq.size()), 64'(1));
        else check("weight_in", 64'(bus.weight_in), 64'(wq.pop_front()));
      end
      if (bus.wt_rd_en) begin
        if (aq.size() == 0) check("wt_addr_extra", 64'(aq.size()), 64'(1));
        else begin
          int a;
          a = aq.pop_front();
          check("wt_addr", 64'(bus.wt_addr), 64'(a));
          wq.push_back(wfun(a));
        end
      end
      if (bus.valid_in) begin
        vin_cnt++;
        if (pq.size() == 0) check("pxl_extra", 64'(pq.size()), 64'(1));
        else check("pxl_in", 64'(bus.pxl_in), 64'(pq.pop_front()));
      end
      if (wrd_rise && bus.oc_index == 1'b1) begin
        check("vin_per_oc", 64'(vin_cnt), 64'(CIN * IMG));
        if (chk_drain) begin
          check("drain_exit_results", 64'(res_seen), 64'(IMG));
          check("drain_exit_on_last", 64'(bus.conv_valid_out), 64'(1));
        end
      end
      if (done) done_cnt++;
      if (busy && bus.stride2 != exp_stride) stride_err++;

      if (acc_pending) src_seq++;
      bus.src_valid = src_toggle ? !bus.src_valid : 1'b1;
      bus.src_data  = bus.src_valid ? 16'(32'h5000 + src_seq) : 16'hDEAD;
      acc_pending   = bus.src_valid && bus.src_ready;
      if (acc_pending) pq.push_back(bus.src_data);

      if (rdy_rise) begin
        res_wait = RES_DELAY;
        res_left = IMG;
      end
      if (res_left > 0) begin
        if (res_wait > 0) begin
          res_wait--;
          bus.conv_valid_out = 1'b0;
        end else begin
          bus.conv_valid_out = 1'b1;
          res_left--;
          res_wait = 1;
        end
      end else begin
        bus.conv_valid_out = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic prepare();
    aq.delete();
    for (int k = 0; k < int'(CIN * COUT); k++) aq.push_back(k);
    wq.delete();
    pq.delete();
    vin_cnt    = 0;
    done_cnt   = 0;
    stride_err = 0;
  endtask

  task automatic start_layer(input bit cfg);
    exp_stride = cfg;
    @(negedge clk);
    start       = 1'b1;
    stride2_cfg = cfg;
    @(negedge clk);
    start       = 1'b0;
    stride2_cfg = !cfg;
    #1;
    check("busy_after_start", 64'(busy), 64'(1));
  endtask

  task automatic wait_done(input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (done) got = 1'b1;
    end
    check("done_seen", 64'(got), 64'(1));
  endtask

  task automatic wait_ready(input bit want_oc1);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      if (bus.src_ready && (bus.oc_index == 1'(want_oc1))) got = 1'b1;
    end
    check("reach_run", 64'(got), 64'(1));
  endtask

  task automatic finish_layer(input int exp_vin, input int exp_done);
    tick();
    tick();
    check("done_count", 64'(done_cnt), 64'(exp_done));
    check("busy_after_done", 64'(busy), 64'(0));
    check("vin_total", 64'(vin_cnt), 64'(exp_vin));
    check("addr_left", 64'(aq.size()), 64'(0));
    check("weight_left", 64'(wq.size()), 64'(0));
    check("pxl_left", 64'(pq.size()), 64'(0));
    check("stride2_hold", 64'(stride_err), 64'(0));
  endtask

  initial begin
    vt[0] = '{cfg: 1'b0, toggle: 1'b0, chk_drain: 1'b1, exp_vin: 24, exp_done: 1};
    vt[1] = '{cfg: 1'b0, toggle: 1'b1, chk_drain: 1'b0, exp_vin: 24, exp_done: 1};
    vt[2] = '{cfg: 1'b1, toggle: 1'b0, chk_drain: 1'b1, exp_vin: 24, exp_done: 1};
    vt[3] = '{cfg: 1'b1, toggle: 1'b1, chk_drain: 1'b0, exp_vin: 24, exp_done: 1};

    reset       = 1'b0;
    start       = 1'b0;
    stride2_cfg = 1'b0;
    src_toggle  = 1'b0;
    chk_drain   = 1'b0;
    exp_stride  = 1'b0;
    src_seq     = 0;
    res_seen    = 0;
    repeat (3) tick();
    check("reset_outputs", 64'({busy, done, bus.wt_rd_en, bus.wt_addr, bus.valid_weight_in,
                                bus.weight_in, bus.stride2, bus.src_ready, bus.valid_in,
                                bus.pxl_in, bus.oc_index}), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("idle_busy", 64'(busy), 64'(0));

    for (int i = 0; i < 4; i++) begin
      src_toggle = vt[i].toggle;
      chk_drain  = vt[i].chk_drain;
      prepare();
      start_layer(vt[i].cfg);
      wait_done(600);
      finish_layer(vt[i].exp_vin, vt[i].exp_done);
    end

    // Start during RUN is ignored; start one cycle after done begins a new layer.
    src_toggle = 1'b0;
    chk_drain  = 1'b1;
    prepare();
    start_layer(1'b0);
    wait_ready(1'b0);
    @(negedge clk);
    start       = 1'b1;
    stride2_cfg = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    stride2_cfg = 1'b0;
    wait_done(600);
    check("ignored_start_addr", 64'(aq.size()), 64'(0));
    check("ignored_start_done", 64'(done_cnt), 64'(1));
    check("ignored_start_vin", 64'(vin_cnt), 64'(24));
    prepare();
    start_layer(1'b0);
    wait_done(600);
    finish_layer(24, 1);

    // Reset during oc=1 RUN abandons the layer; next start restarts at oc 0.
    prepare();
    start_layer(1'b0);
    wait_ready(1'b1);
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    check("reset_async_clear", 64'({busy, done, bus.wt_rd_en, bus.wt_addr, bus.valid_weight_in,
                                    bus.weight_in, bus.stride2, bus.src_ready, bus.valid_in,
                                    bus.pxl_in, bus.oc_index}), 64'(0));
    repeat (4) tick();
    check("no_done_on_abort", 64'(done_cnt), 64'(0));
    prepare();
    @(negedge clk);
    reset = 1'b1;
    tick();
    start_layer(1'b0);
    wait_done(600);
    finish_layer(24, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Hard stop if the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_1x1_sched.md
CONV_1X1_SCHED -- requirements
Module: conv_1x1_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, pixel/weight word width.
REQ-002 SHALL have parameter CHANNEL_NUM_IN, default 304, input channels per output channel.
REQ-003 SHALL have parameter CHANNEL_NUM_OUT, default 256, output channels to sequence.
REQ-004 SHALL have parameter IMAGE_SIZE, default 4096, pixels per channel plane.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle request to run a full layer.
REQ-008 SHALL have port stride2_cfg  input  1  stride-2 mode, sampled on accepted start.
REQ-009 SHALL have ports busy, done  output  1 each  layer in progress; one-cycle completion pulse.
REQ-010 SHALL have ports wt_rd_en (output, 1), wt_addr (output, clog2(CIN*COUT)), wt_data (input, DATA_WIDTH)  weight memory read port, one-cycle read latency.
REQ-011 SHALL have ports valid_weight_in (output, 1), weight_in (output, DATA_WIDTH), stride2 (output, 1)  weight load and mode to the conv datapath.
REQ-012 SHALL have ports src_valid (input, 1), src_data (input, DATA_WIDTH), src_ready (output, 1)  pixel source handshake.
REQ-013 SHALL have ports valid_in (output, 1), pxl_in (output, DATA_WIDTH)  pixel stream to the conv datapath.
REQ-014 SHALL have ports conv_valid_out (input, 1), oc_index (output, clog2(COUT))  datapath result strobe; current output channel.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD_W, RUN, DRAIN, DONE.
REQ-016 IDLE: start=1 SHALL latch stride2_cfg, clear oc counter, go to LOAD_W; start outside IDLE SHALL be ignored.
REQ-017 LOAD_W: SHALL assert wt_rd_en for exactly CHANNEL_NUM_IN consecutive cycles, wt_addr = oc*CHANNEL_NUM_IN + k, k = 0..CIN-1.
REQ-018 valid_weight_in SHALL equal wt_rd_en delayed one cycle, with weight_in = wt_data in that cycle.
REQ-019 After the last weight beat is forwarded, FSM SHALL enter RUN on the next cycle.
REQ-020 RUN: src_ready SHALL be 1; elsewhere 0.
REQ-021 Each src_valid&src_ready beat SHALL produce valid_in=1, pxl_in=src_data, registered, one cycle later.
REQ-022 RUN SHALL exit to DRAIN after exactly CHANNEL_NUM_IN*IMAGE_SIZE accepted beats; the beat counter SHALL hold while src_valid=0.
REQ-023 Results SHALL be counted on conv_valid_out in RUN and DRAIN; DRAIN SHALL exit when IMAGE_SIZE results are counted for the current oc.
REQ-024 DRAIN exit: oc < COUT-1 -> increment oc, clear counters, go to LOAD_W; oc = COUT-1 -> DONE.
REQ-025 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-026 busy SHALL be 1 in LOAD_W, RUN, DRAIN and DONE, 0 in IDLE.
REQ-027 conv_valid_out in IDLE SHALL be ignored.
REQ-028 stride2 SHALL hold the latched value for the whole layer.
REQ-029 oc_index SHALL equal the oc counter.
REQ-030 Counter widths SHALL come from clog2 of their terminal counts; wrap-around SHALL never occur within a layer.

Reset
REQ-031 reset=0 SHALL asynchronously force IDLE and clear all counters.
REQ-032 reset=0 SHALL clear busy, done, wt_rd_en, wt_addr, valid_weight_in, weight_in, stride2, src_ready, valid_in, pxl_in and oc_index to 0.
REQ-033 reset asserted mid-layer SHALL abandon the layer with no done pulse.
REQ-034 After reset release, the first start SHALL begin from oc=0.

Structure
REQ-035 FSM state encoding and the clog2 width constants SHALL live in the shared conv parameter include file.
REQ-036 A sub-module conv_sched_cnt (parameterised terminal count, enable, clear, last flag) SHALL implement the weight, beat, result and oc counters.

Verification
REQ-037 Use CIN=4, COUT=2, IMAGE_SIZE=3 unless stated.
REQ-038 start, source always valid -> wt_addr 0,1,2,3 then 4,5,6,7; 12 valid_in beats per oc; done exactly once; busy 0 after.
REQ-039 src_valid toggling 1,0 -> still exactly 12 valid_in per oc; src_data order preserved.
REQ-040 conv_valid_out pulses delayed 20 cycles after RUN -> FSM stays in DRAIN until the 3rd pulse, then LOAD_W with oc_index=1.
REQ-041 start pulsed during RUN -> ignored; a start one cycle after done -> new layer from wt_addr 0.
REQ-042 reset=0 during oc=1 RUN -> all outputs 0 immediately; no done; next start restarts at oc=0.
REQ-043 stride2_cfg=1 at start, then 0 -> stride2 stays 1 until IDLE.
